// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the sample buffer arbiter.
//   DEF_ADDR_W / DEF_DATA_W : default frame index width and sample width
//   FRAME_LEN               : samples per ping-pong bank
//   grant_e                 : which side won the last RAM contention
package audio_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int FRAME_LEN  = 1 << DEF_ADDR_W;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  // Winner of a contention cycle: the side that did not win the previous one.
  function automatic grant_e rr_winner(input grant_e last_grant);
    return (last_grant == GRANT_RD) ? GRANT_WR : GRANT_RD;
  endfunction

endpackage

// File: rtl/sample_buffer_arbiter_if.sv
// sample_buffer_arbiter_if: bundles the writer stream, FFT read port,
// frame handshake and RAM port of the sample buffer arbiter.
//   slave  : view of the arbiter (consumes requests, drives grants and RAM)
//   master : view of the surrounding system (writer, FFT and RAM model)
interface sample_buffer_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);

  // writer
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  // FFT reader
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_grant;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  // frame handshake / status
  logic              frame_ready;
  logic              frame_ack;
  logic              overflow;
  // single-port RAM
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  wr_valid, wr_data, rd_req, rd_addr, frame_ack, mem_rdata,
    output wr_ready, rd_grant, rd_valid, rd_data, frame_ready, overflow,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output wr_valid, wr_data, rd_req, rd_addr, frame_ack, mem_rdata,
    input  wr_ready, rd_grant, rd_valid, rd_data, frame_ready, overflow,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sample_buffer_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin arbiter (writer vs reader).
//   clk, reset     : clock, asynchronous active-high reset
//   req_wr, req_rd : requests from writer and (eligible) reader
//   gnt_wr, gnt_rd : one-hot-or-zero grants, combinational in the cycle
// A lone requester is always granted. On contention the side that lost the
// previous contention wins; last_grant_reg only moves on contention cycles.
module rr_arbiter2
  import audio_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

  grant_e last_grant_reg;
  grant_e winner;
  logic   contention;

  assign contention = req_wr & req_rd;
  assign winner     = rr_winner(last_grant_reg);

  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (contention) begin
      gnt_wr = (winner == GRANT_WR);
      gnt_rd = (winner == GRANT_RD);
    end else begin
      gnt_wr = req_wr;
      gnt_rd = req_rd;
    end
  end

  // Reset to GRANT_RD so the writer wins the first contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= GRANT_RD;
    end else if (contention) begin
      last_grant_reg <= winner;
    end
  end

endmodule

// File: rtl/sample_buffer_arbiter.sv
// sample_buffer_arbiter: shares one single-port sample RAM between the audio
// capture writer and the FFT reader using two ping-pong banks.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : sample_buffer_arbiter_if.slave
//     wr_valid/wr_data/wr_ready         writer handshake
//     rd_req/rd_addr/rd_grant           FFT read request into the ready bank
//     rd_valid/rd_data                  read return, one cycle after rd_grant
//     frame_ready/frame_ack             complete frame available / released
//     overflow                          sticky: a frame was dropped
//     mem_en/we/addr/wdata/rdata        RAM port, addr = {bank, index}
// The writer fills bank wr_bank while the reader sees bank ~wr_bank.
module sample_buffer_arbiter
  import audio_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  sample_buffer_arbiter_if.slave  bus
);

  logic              wr_bank_reg, wr_bank_next;
  logic [ADDR_W-1:0] wr_idx_reg, wr_idx_next;
  logic              frame_ready_reg, frame_ready_next;
  logic              overflow_reg, overflow_next;
  logic              rd_valid_reg;

  logic req_wr, req_rd;
  logic gnt_wr, gnt_rd;
  logic last_write;

  // Requests are masked while reset is held so every output reads 0.
  // Reads are only eligible while a complete frame is available.
  assign req_wr = bus.wr_valid & ~reset;
  assign req_rd = bus.rd_req & frame_ready_reg & ~reset;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .reset  (reset),
    .req_wr (req_wr),
    .req_rd (req_rd),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  assign last_write = gnt_wr && (wr_idx_reg == {ADDR_W{1'b1}});

  // RAM port and handshake outputs
  assign bus.wr_ready  = gnt_wr;
  assign bus.rd_grant  = gnt_rd;
  assign bus.mem_en    = gnt_wr | gnt_rd;
  assign bus.mem_we    = gnt_wr;
  assign bus.mem_addr  = gnt_wr ? {wr_bank_reg, wr_idx_reg} :
                         gnt_rd ? {~wr_bank_reg, bus.rd_addr} : '0;
  assign bus.mem_wdata = gnt_wr ? bus.wr_data : '0;

  // Read data passes straight through; only the data path touches mem_rdata.
  assign bus.rd_valid    = rd_valid_reg;
  assign bus.rd_data     = rd_valid_reg ? bus.mem_rdata : '0;
  assign bus.frame_ready = frame_ready_reg;
  assign bus.overflow    = overflow_reg;

  // Bank/index control. On the last write of a frame the bank swaps only if
  // the reader has released (or is releasing) its bank; otherwise the frame
  // is dropped and the same bank is refilled from index 0.
  always_comb begin
    wr_bank_next     = wr_bank_reg;
    wr_idx_next      = wr_idx_reg;
    frame_ready_next = frame_ready_reg;
    overflow_next    = overflow_reg;

    if (gnt_wr) begin
      wr_idx_next = wr_idx_reg + 1'b1;
    end

    if (last_write) begin
      if (!frame_ready_reg || bus.frame_ack) begin
        wr_bank_next     = ~wr_bank_reg;
        frame_ready_next = 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
    end else if (bus.frame_ack) begin
      frame_ready_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank_reg     <= 1'b0;
      wr_idx_reg      <= '0;
      frame_ready_reg <= 1'b0;
      overflow_reg    <= 1'b0;
      rd_valid_reg    <= 1'b0;
    end else begin
      wr_bank_reg     <= wr_bank_next;
      wr_idx_reg      <= wr_idx_next;
      frame_ready_reg <= frame_ready_next;
      overflow_reg    <= overflow_next;
      rd_valid_reg    <= gnt_rd;
    end
  end

endmodule

// File: tb/tb_sample_buffer_arbiter.sv
// Self-checking bench for sample_buffer_arbiter. A reference model of the
// buffer (bank, index, frame state, contention winner, stored samples) is
// advanced every cycle and compared with the DUT at mid-cycle.
module tb_sample_buffer_arbiter;
  import audio_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int LEN = 1 << AW;

  logic clk;
  logic reset;

  sample_buffer_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sample_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural single-port RAM, 1-cycle read latency
  logic [DW-1:0] ram [0:2*LEN-1];
  logic [DW-1:0] rdata_q;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            rdata_q <= ram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = rdata_q;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [DW-1:0] mirror [0:2*LEN-1];
  int   m_bank, m_idx;
  bit   m_ready, m_ovf, m_wr_won_last;
  bit   m_pend_valid;
  logic [DW-1:0] m_pend_data;

  // last observed values, for scenario-specific checks
  logic          obs_wr, obs_rd, obs_fr, obs_ovf, obs_rv;
  logic [AW:0]   obs_addr;
  logic [DW-1:0] obs_rdata;

  task automatic model_reset();
    m_bank = 0; m_idx = 0; m_ready = 0; m_ovf = 0;
    m_wr_won_last = 0; m_pend_valid = 0; m_pend_data = '0;
  endtask

  // Drive one cycle of inputs, check mid-cycle, advance model and clock.
  task automatic cycle(input logic wv, input logic [DW-1:0] wd, input logic rq,
                       input logic [AW-1:0] ra, input logic ack);
    bit elig, win_w, e_wr, e_rd, completes;
    logic [AW:0] e_addr;
    bus.wr_valid = wv; bus.wr_data = wd; bus.rd_req = rq;
    bus.rd_addr = ra; bus.frame_ack = ack;
    #4;
    elig  = rq && m_ready;
    win_w = !m_wr_won_last;
    e_wr  = wv && (!elig || win_w);
    e_rd  = elig && (!wv || !win_w);
    e_addr = e_wr ? {m_bank[0], m_idx[AW-1:0]} : {~m_bank[0], ra};

    obs_wr = bus.wr_ready; obs_rd = bus.rd_grant; obs_addr = bus.mem_addr;
    obs_fr = bus.frame_ready; obs_ovf = bus.overflow;
    obs_rv = bus.rd_valid; obs_rdata = bus.rd_data;

    n_tests++;
    if ({bus.wr_ready, bus.rd_grant, bus.mem_en, bus.mem_we} !==
        {e_wr, e_rd, e_wr | e_rd, e_wr}) begin
      n_fail++;
      $display("FAIL arb t=%0t got wr_ready/rd_grant/en/we=%b%b%b%b need %b%b%b%b",
               $time, bus.wr_ready, bus.rd_grant, bus.mem_en, bus.mem_we,
               e_wr, e_rd, e_wr | e_rd, e_wr);
    end
    if (e_wr || e_rd) begin
      n_tests++;
      if (bus.mem_addr !== e_addr || (e_wr && bus.mem_wdata !== wd)) begin
        n_fail++;
        $display("FAIL mem_port t=%0t got addr=%h wdata=%h need addr=%h wdata=%h",
                 $time, bus.mem_addr, bus.mem_wdata, e_addr, wd);
      end
    end
    n_tests++;
    if (bus.rd_valid !== m_pend_valid ||
        (m_pend_valid && bus.rd_data !== m_pend_data)) begin
      n_fail++;
      $display("FAIL rd_return t=%0t got valid=%b data=%h need valid=%b data=%h",
               $time, bus.rd_valid, bus.rd_data, m_pend_valid, m_pend_data);
    end
    n_tests++;
    if ({bus.frame_ready, bus.overflow} !== {m_ready, m_ovf}) begin
      n_fail++;
      $display("FAIL status t=%0t got frame_ready=%b overflow=%b need %b %b",
               $time, bus.frame_ready, bus.overflow, m_ready, m_ovf);
    end

    // model update
    if (wv && elig) m_wr_won_last = win_w;
    m_pend_valid = e_rd;
    if (e_rd) m_pend_data = mirror[{~m_bank[0], ra}];
    completes = e_wr && (m_idx == LEN - 1);
    if (e_wr) begin
      mirror[{m_bank[0], m_idx[AW-1:0]}] = wd;
      m_idx = (m_idx + 1) % LEN;
    end
    if (completes) begin
      if (!m_ready || ack) begin
        m_bank = 1 - m_bank;
        m_ready = 1;
      end else begin
        m_ovf = 1;
      end
    end else if (ack) begin
      m_ready = 0;
    end

    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic write(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0, '0, 1'b0);
  endtask

  // Reset with requests active: everything must read 0 while reset is held.
  task automatic do_reset();
    bus.wr_valid = 1'b1; bus.wr_data = 16'hBEEF; bus.rd_req = 1'b1;
    bus.rd_addr = 10'h3; bus.frame_ack = 1'b0;
    reset = 1'b1;
    #4;
    n_tests++;
    if ({bus.wr_ready, bus.rd_grant, bus.rd_valid, bus.rd_data, bus.frame_ready,
         bus.overflow, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs t=%0t got wr=%b rg=%b rv=%b rd=%h fr=%b ovf=%b en=%b we=%b addr=%h wd=%h need all 0",
               $time, bus.wr_ready, bus.rd_grant, bus.rd_valid, bus.rd_data,
               bus.frame_ready, bus.overflow, bus.mem_en, bus.mem_we,
               bus.mem_addr, bus.mem_wdata);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.wr_valid = 1'b0; bus.rd_req = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    idle();
  endtask

  task automatic test_fill_frame();
    for (int i = 0; i < LEN; i++) begin
      write(DW'(i));
      n_tests++;
      if (obs_wr !== 1'b1 || obs_addr !== 11'(i) || obs_fr !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_addr i=%0d got wr_ready=%b addr=%h frame_ready=%b need 1 %h 0",
                 i, obs_wr, obs_addr, obs_fr, 11'(i));
      end
    end
    idle();
    n_tests++;
    if (obs_fr !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_frame_ready got %b need 1", obs_fr);
    end
  endtask

  task automatic test_read();
    cycle(1'b0, '0, 1'b1, 10'd5, 1'b0);
    n_tests++;
    if (obs_rd !== 1'b1 || obs_addr !== 11'h005) begin
      n_fail++;
      $display("FAIL read_issue got rd_grant=%b addr=%h need 1 005", obs_rd, obs_addr);
    end
    idle();
    n_tests++;
    if (obs_rv !== 1'b1 || obs_rdata !== 16'd5) begin
      n_fail++;
      $display("FAIL read_return got rd_valid=%b rd_data=%h need 1 0005", obs_rv, obs_rdata);
    end
  endtask

  task automatic test_contention();
    logic [3:0] wpat, rpat;
    logic [AW:0] first_waddr;
    int nw;
    nw = 0;
    first_waddr = '1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'h1000 + 16'(nw), 1'b1, 10'(i + 7), 1'b0);
      wpat[3-i] = obs_wr;
      rpat[3-i] = obs_rd;
      if (obs_wr === 1'b1) begin
        if (nw == 0) first_waddr = obs_addr;
        nw++;
      end
    end
    idle();
    n_tests++;
    if (wpat !== 4'b1010 || rpat !== 4'b0101) begin
      n_fail++;
      $display("FAIL contention_pattern got wr=%b rd=%b need wr=1010 rd=0101", wpat, rpat);
    end
    n_tests++;
    if (first_waddr !== 11'h400) begin
      n_fail++;
      $display("FAIL bank1_first_write got addr=%h need 400", first_waddr);
    end
  endtask

  task automatic test_overflow();
    // two samples of frame 1 were written during the contention test
    for (int i = 2; i < LEN; i++) write(16'h2000 + 16'(i));
    write(16'h3000);
    n_tests++;
    if (obs_ovf !== 1'b1 || obs_fr !== 1'b1 || obs_addr !== 11'h400) begin
      n_fail++;
      $display("FAIL overflow got overflow=%b frame_ready=%b addr=%h need 1 1 400",
               obs_ovf, obs_fr, obs_addr);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    for (int i = 0; i < LEN + 300; i++) write(DW'($urandom));
    do_reset();
    write(16'h4444);
    n_tests++;
    if (obs_addr !== 11'h000 || obs_fr !== 1'b0 || obs_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid got addr=%h frame_ready=%b overflow=%b need 000 0 0",
               obs_addr, obs_fr, obs_ovf);
    end
  endtask

  task automatic test_ack_same_cycle();
    // one sample already written after the reset; finish frame 0, then frame 1
    for (int i = 1; i < LEN; i++) write(DW'($urandom));
    for (int i = 0; i < LEN - 1; i++) write(DW'($urandom));
    cycle(1'b1, 16'h5555, 1'b0, '0, 1'b1);
    write(16'h6666);
    n_tests++;
    if (obs_fr !== 1'b1 || obs_ovf !== 1'b0 || obs_addr !== 11'h000) begin
      n_fail++;
      $display("FAIL ack_same_cycle got frame_ready=%b overflow=%b addr=%h need 1 0 000",
               obs_fr, obs_ovf, obs_addr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom_range(0, 9) < 8), DW'($urandom), ($urandom_range(0, 1) == 1),
            AW'($urandom), ($urandom_range(0, 399) == 0));
    end
    idle();
  endtask

  initial begin
    for (int i = 0; i < 2 * LEN; i++) begin
      ram[i] = '0;
      mirror[i] = '0;
    end
    rdata_q = '0;
    reset = 1'b1;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_req = 1'b0;
    bus.rd_addr = '0; bus.frame_ack = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_fill_frame();
    test_read();
    test_contention();
    test_overflow();
    test_reset_mid_frame();
    test_ack_same_cycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
